// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory slave with configurable wait states, ready pulse and error flag.
// Revision 1.0
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] address,
  input  logic [15:0] writeData,
  output logic [15:0] outputDataRead,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int         DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    invalid_q, invalid_d;
  logic [15:0]             rdata_q, rdata_d;
  logic [15:0]             mem_q [DEPTH];

  logic                    req;
  logic                    out_of_range;
  logic                    req_invalid;
  logic                    do_access;
  logic                    acc_write;
  logic                    acc_invalid;
  logic [DEPTH_LOG2-1:0]   acc_addr;
  logic [15:0]             acc_data;
  logic                    mem_we;

  generate
    if (DEPTH_LOG2 < 16) begin : g_range_check
      assign out_of_range = |address[15:DEPTH_LOG2];
    end else begin : g_full_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign req         = MemRead | MemWrite;
  assign req_invalid = (MemRead & MemWrite) | out_of_range;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    invalid_d   = invalid_q;
    rdata_d     = rdata_q;
    do_access   = 1'b0;
    acc_addr    = addr_q;
    acc_data    = wdata_q;
    acc_write   = write_q;
    acc_invalid = invalid_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = address[DEPTH_LOG2-1:0];
          wdata_d   = writeData;
          write_d   = MemWrite;
          invalid_d = req_invalid;
          if (WAIT_STATES == 0) begin
            // Zero wait states: the access happens on the capture edge, from live inputs.
            state_d     = S_RESP;
            do_access   = 1'b1;
            acc_addr    = address[DEPTH_LOG2-1:0];
            acc_data    = writeData;
            acc_write   = MemWrite;
            acc_invalid = req_invalid;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
      if (acc_invalid) begin
        rdata_d = 16'h0000;
      end else if (!acc_write) begin
        rdata_d = mem_q[acc_addr];
      end
    end
  end

  assign mem_we = do_access & acc_write & ~acc_invalid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 16'h0000;
      write_q   <= 1'b0;
      invalid_q <= 1'b0;
      rdata_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      invalid_q <= invalid_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (mem_we) begin
      mem_q[acc_addr] <= acc_data;
    end
  end

  assign outputDataRead = rdata_q;
  assign ready          = (state_q == S_RESP);
  assign busy           = (state_q != S_IDLE);
  assign error          = (state_q == S_RESP) & invalid_q;

endmodule

`default_nettype wire
